// File: rtl/b2b_pkg.sv
// Shared constants, word/state enums and field helpers for the
// board-to-board input merger.
package b2b_pkg;

    localparam int         WORD_W       = 65;
    localparam logic [7:0] B2B_HDR_FLAG = 8'hAB;
    localparam logic [7:0] B2B_FTR_FLAG = 8'hCD;

    typedef enum logic [1:0] {
        WC_DATA = 2'd0,
        WC_HDR  = 2'd1,
        WC_FTR  = 2'd2
    } wclass_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_FTR  = 2'd3
    } state_t;

    function automatic logic [31:0] l0id(
        input logic [WORD_W-1:0] w
    );
        return w[31:0];
    endfunction

endpackage

// File: rtl/b2b_word_classify.sv
// Word classifier: header/footer/data class and L0ID of one word.
// Ports: word in; wclass, word_l0id out (combinational).
module b2b_word_classify
    import b2b_pkg::*;
#(
    parameter int         DATA_WIDTH = WORD_W,
    parameter logic [7:0] HDR_FLAG   = B2B_HDR_FLAG,
    parameter logic [7:0] FTR_FLAG   = B2B_FTR_FLAG
) (
    input  logic [DATA_WIDTH-1:0] word,
    output wclass_t               wclass,
    output logic [31:0]           word_l0id
);

    always_comb begin
        wclass = WC_DATA;
        if (word[DATA_WIDTH-1]) begin
            if (word[63:56] == HDR_FLAG)
                wclass = WC_HDR;
            else if (word[63:56] == FTR_FLAG)
                wclass = WC_FTR;
        end
    end

    assign word_l0id = l0id(word);

endmodule

// File: rtl/b2b_input_merger.sv
// Merges per-event fragments from N FWFT input FIFOs into one stream.
// Ports: clock/reset, in_data/in_empty/in_rd_en per input, out_data/
// out_wren/out_almost_full downstream, event_done, err_*, busy.
module b2b_input_merger
    import b2b_pkg::*;
#(
    parameter int         DATA_WIDTH         = 65,
    parameter int         TOTAL_INPUT_BOARDS = 14,
    parameter logic [7:0] HDR_FLAG           = 8'hAB,
    parameter logic [7:0] FTR_FLAG           = 8'hCD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data  [TOTAL_INPUT_BOARDS],
    input  logic                  in_empty [TOTAL_INPUT_BOARDS],
    output logic                  in_rd_en [TOTAL_INPUT_BOARDS],
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wren,
    input  logic                  out_almost_full,
    output logic                  event_done,
    output logic                  err_l0id_mismatch,
    output logic                  err_framing,
    output logic                  busy
);

    localparam int N     = TOTAL_INPUT_BOARDS;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [DATA_WIDTH-1:0] SYNTH_FTR =
        {1'b1, FTR_FLAG, {(DATA_WIDTH-9){1'b0}}};

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] hdr_q;
    logic [DATA_WIDTH-1:0] ftr_q;
    logic                  stall;

    wclass_t               in_class [N];
    logic [31:0]           in_l0id  [N];
    logic [DATA_WIDTH-1:0] head;
    wclass_t               head_class;
    logic [31:0]           unused_head_l0id;

    logic                  all_hdr;
    logic                  l0id_diff;
    logic                  drop_hit;
    logic [IDX_W-1:0]      drop_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_cls
        b2b_word_classify #(
            .DATA_WIDTH (DATA_WIDTH),
            .HDR_FLAG   (HDR_FLAG),
            .FTR_FLAG   (FTR_FLAG)
        ) u_cls (
            .word      (in_data[gi]),
            .wclass    (in_class[gi]),
            .word_l0id (in_l0id[gi])
        );
    end

    assign head = in_data[idx];

    b2b_word_classify #(
        .DATA_WIDTH (DATA_WIDTH),
        .HDR_FLAG   (HDR_FLAG),
        .FTR_FLAG   (FTR_FLAG)
    ) u_head_cls (
        .word      (head),
        .wclass    (head_class),
        .word_l0id (unused_head_l0id)
    );

    assign stall = out_almost_full;
    assign busy  = (state != ST_IDLE);

    // Header alignment check and lowest-index stray-word finder.
    always_comb begin
        all_hdr   = 1'b1;
        l0id_diff = 1'b0;
        drop_hit  = 1'b0;
        drop_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (in_empty[i] || in_class[i] != WC_HDR)
                all_hdr = 1'b0;
            if (in_l0id[i] != in_l0id[0])
                l0id_diff = 1'b1;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (!in_empty[i] && in_class[i] != WC_HDR) begin
                drop_hit = 1'b1;
                drop_idx = IDX_W'(i);
            end
        end
    end

    // Pops and error pulses are combinational so they line up
    // with the pop itself; reset masks them so nothing drains
    // while the block is being cleared.
    always_comb begin
        for (int i = 0; i < N; i++)
            in_rd_en[i] = 1'b0;
        err_framing       = 1'b0;
        err_l0id_mismatch = 1'b0;
        if (!reset && !stall) begin
            unique case (state)
                ST_IDLE: begin
                    if (all_hdr) begin
                        for (int i = 0; i < N; i++)
                            in_rd_en[i] = 1'b1;
                        err_l0id_mismatch = l0id_diff;
                    end else if (drop_hit) begin
                        in_rd_en[drop_idx] = 1'b1;
                        err_framing        = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (!in_empty[idx]) begin
                        // A header here means the footer went missing;
                        // leave it for the next event.
                        if (head_class == WC_HDR)
                            err_framing = 1'b1;
                        else
                            in_rd_en[idx] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            hdr_q      <= '0;
            ftr_q      <= '0;
            out_data   <= '0;
            out_wren   <= 1'b0;
            event_done <= 1'b0;
        end else begin
            out_wren   <= 1'b0;
            event_done <= 1'b0;
            if (!stall) begin
                unique case (state)
                    ST_IDLE: begin
                        if (all_hdr) begin
                            hdr_q <= in_data[0];
                            state <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        out_data <= hdr_q;
                        out_wren <= 1'b1;
                        idx      <= '0;
                        state    <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (!in_empty[idx]) begin
                            if (head_class == WC_DATA) begin
                                out_data <= head;
                                out_wren <= 1'b1;
                            end else begin
                                if (idx == '0)
                                    ftr_q <= (head_class == WC_FTR) ?
                                             head : SYNTH_FTR;
                                if (idx == LAST_IDX)
                                    state <= ST_FTR;
                                else
                                    idx <= idx + 1'b1;
                            end
                        end
                    end
                    ST_FTR: begin
                        out_data   <= ftr_q;
                        out_wren   <= 1'b1;
                        event_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_b2b_input_merger.sv
// Directed bench for b2b_input_merger with modelled FWFT inputs.
// Ports: none; drives the DUT and prints one summary line.
module tb_b2b_input_merger;

    localparam int W = 65;
    localparam int N = 14;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] in_data  [N];
    logic         in_empty [N];
    logic         in_rd_en [N];
    logic [W-1:0] out_data;
    logic         out_wren;
    logic         out_almost_full;
    logic         event_done;
    logic         err_l0id_mismatch;
    logic         err_framing;
    logic         busy;

    logic [W-1:0] fifo_q [N][$];
    logic [W-1:0] out_log[$];
    logic [W-1:0] exp_log[$];

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int done_cnt;
    int frm_cnt;
    int mis_cnt;
    int viol_cnt;

    always #5 clock = ~clock;

    b2b_input_merger dut (
        .clock             (clock),
        .reset             (reset),
        .in_data           (in_data),
        .in_empty          (in_empty),
        .in_rd_en          (in_rd_en),
        .out_data          (out_data),
        .out_wren          (out_wren),
        .out_almost_full   (out_almost_full),
        .event_done        (event_done),
        .err_l0id_mismatch (err_l0id_mismatch),
        .err_framing       (err_framing),
        .busy              (busy)
    );

    function automatic logic [W-1:0] hdr_w(input logic [31:0] id);
        return {1'b1, 8'hAB, 24'h0, id};
    endfunction

    function automatic logic [W-1:0] ftr_w(input logic [31:0] tag);
        return {1'b1, 8'hCD, 24'h0, tag};
    endfunction

    function automatic logic [W-1:0] dat_w(input logic [63:0] v);
        return {1'b0, v};
    endfunction

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (fifo_q[i].size() > 0) begin
                in_data[i]  = fifo_q[i][0];
                in_empty[i] = 1'b0;
            end else begin
                in_data[i]  = '0;
                in_empty[i] = 1'b1;
            end
        end
    endtask

    // One clock: sample combinational pops/pulses mid-cycle, sample
    // registered outputs just after the edge, then apply the pops.
    task automatic tick();
        logic rd [N];
        bit   any;
        bit   st;
        #1;
        any = 0;
        st  = out_almost_full;
        for (int i = 0; i < N; i++) begin
            rd[i] = in_rd_en[i];
            if (rd[i]) begin
                any = 1;
                if (in_empty[i]) viol_cnt++;
            end
        end
        if (any && (st || reset)) viol_cnt++;
        if (err_framing) frm_cnt++;
        if (err_l0id_mismatch) mis_cnt++;
        @(posedge clock);
        #1;
        if (out_wren) begin
            out_log.push_back(out_data);
            if (st) viol_cnt++;
        end
        if (event_done) begin
            done_cnt++;
            if (!out_wren) viol_cnt++;
        end
        for (int i = 0; i < N; i++)
            if (rd[i] && fifo_q[i].size() > 0)
                void'(fifo_q[i].pop_front());
        @(negedge clock);
        drive();
    endtask

    task automatic clear_stats();
        out_log.delete();
        exp_log.delete();
        done_cnt = 0;
        frm_cnt  = 0;
        mis_cnt  = 0;
        viol_cnt = 0;
    endtask

    task automatic load_event(input logic [31:0] id,
                              input int          odd_i,
                              input logic [31:0] odd_id,
                              input int          nd);
        logic [W-1:0] w;
        exp_log.push_back(hdr_w(id));
        for (int i = 0; i < N; i++) begin
            fifo_q[i].push_back(hdr_w(i == odd_i ? odd_id : id));
            for (int k = 0; k < nd; k++) begin
                w = dat_w(64'h1000 + 64'(i * 16 + k));
                fifo_q[i].push_back(w);
                exp_log.push_back(w);
            end
            fifo_q[i].push_back(ftr_w(32'hF000 + 32'(i)));
        end
        exp_log.push_back(ftr_w(32'hF000));
        drive();
    endtask

    task automatic run_event(input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk("event_timeout", W'(done_cnt != start), W'(1));
        tick();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, W'(out_log.size()), W'(exp_log.size()));
        for (int i = 0; i < out_log.size() && i < exp_log.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), out_log[i], exp_log[i]);
    endtask

    function automatic int fifo_total();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += fifo_q[i].size();
        return s;
    endfunction

    initial begin
        logic [W-1:0] held0;
        logic [W-1:0] held1;
        int           n;

        reset           = 1'b1;
        out_almost_full = 1'b0;
        clear_stats();
        drive();
        tick();
        tick();
        chk("rst_wren",  W'(out_wren), W'(0));
        chk("rst_data",  out_data, '0);
        chk("rst_done",  W'(event_done), W'(0));
        chk("rst_busy",  W'(busy), W'(0));
        chk("rst_frm",   W'(err_framing), W'(0));
        chk("rst_l0id",  W'(err_l0id_mismatch), W'(0));
        reset = 1'b0;

        // Single event, normal flow.
        clear_stats();
        load_event(32'h5, -1, 32'h0, 2);
        run_event(200);
        check_log("t1");
        chk("t1_done", W'(done_cnt), W'(1));
        chk("t1_frm",  W'(frm_cnt), W'(0));
        chk("t1_mis",  W'(mis_cnt), W'(0));
        chk("t1_busy", W'(busy), W'(0));
        chk("t1_viol", W'(viol_cnt), W'(0));
        chk("t1_fifo", W'(fifo_total()), W'(0));

        // Downstream stall and an input running dry mid-fragment.
        clear_stats();
        load_event(32'h5, -1, 32'h0, 2);
        held1 = fifo_q[3].pop_back();
        held0 = fifo_q[3].pop_back();
        drive();
        n = 0;
        while (out_log.size() < 5 && n < 100) begin
            tick();
            n++;
        end
        out_almost_full = 1'b1;
        repeat (10) tick();
        chk("t2_stall_len", W'(out_log.size()), W'(5));
        out_almost_full = 1'b0;
        repeat (10) tick();
        chk("t2_hold_len", W'(out_log.size()), W'(8));
        chk("t2_hold_busy", W'(busy), W'(1));
        fifo_q[3].push_back(held0);
        fifo_q[3].push_back(held1);
        drive();
        run_event(200);
        check_log("t2");
        chk("t2_done", W'(done_cnt), W'(1));
        chk("t2_frm",  W'(frm_cnt), W'(0));
        chk("t2_viol", W'(viol_cnt), W'(0));

        // L0ID mismatch on input 7.
        clear_stats();
        load_event(32'h5, 7, 32'h6, 2);
        run_event(200);
        check_log("t3");
        chk("t3_mis",  W'(mis_cnt), W'(1));
        chk("t3_done", W'(done_cnt), W'(1));
        chk("t3_frm",  W'(frm_cnt), W'(0));
        chk("t3_viol", W'(viol_cnt), W'(0));

        // Stray data ahead of the header on input 2.
        clear_stats();
        fifo_q[2].push_back(dat_w(64'hDEAD));
        fifo_q[2].push_back(dat_w(64'hBEEF));
        load_event(32'h8, -1, 32'h0, 1);
        run_event(200);
        check_log("t4");
        chk("t4_frm",  W'(frm_cnt), W'(2));
        chk("t4_done", W'(done_cnt), W'(1));
        chk("t4_mis",  W'(mis_cnt), W'(0));
        chk("t4_viol", W'(viol_cnt), W'(0));

        // Empty fragments on every input.
        clear_stats();
        load_event(32'h9, -1, 32'h0, 0);
        run_event(200);
        check_log("t5");
        chk("t5_len2", W'(out_log.size()), W'(2));
        chk("t5_done", W'(done_cnt), W'(1));
        chk("t5_frm",  W'(frm_cnt), W'(0));

        // Reset in the middle of the data phase.
        clear_stats();
        load_event(32'hA, -1, 32'h0, 2);
        n = 0;
        while (out_log.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        chk("t6_wren", W'(out_wren), W'(0));
        chk("t6_data", out_data, '0);
        chk("t6_done", W'(event_done), W'(0));
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_frm",  W'(err_framing), W'(0));
        chk("t6_rd0",  W'(in_rd_en[0]), W'(0));
        reset   = 1'b0;
        frm_cnt = 0;
        repeat (60) tick();
        chk("t6_drops", W'(frm_cnt), W'(40));
        chk("t6_fifo",  W'(fifo_total()), W'(0));
        chk("t6_len",   W'(out_log.size()), W'(3));
        chk("t6_ndone", W'(done_cnt), W'(0));
        chk("t6_idle",  W'(busy), W'(0));
        chk("t6_viol",  W'(viol_cnt), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, miss_cnt);
        $finish;
    end

endmodule
